// File: rtl/rr_arb_pkg.sv
// Shared constants and types for the eight-client round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_CLIENTS = 8;
  localparam int unsigned IDX_W     = 3;
  localparam int unsigned HOLD_W    = 16;

  // IDLE: waiting for any request; GRANT: one client owns the decoder enable.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping mod 8.
module rr_pick8
  import rr_arb_pkg::*;
(
  input  logic [N_CLIENTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic                 any,
  output logic [IDX_W-1:0]     winner
);

  logic [N_CLIENTS-1:0] w_rot;
  logic [IDX_W-1:0]     w_off;

  // Rotate so the client at ptr lands in bit 0; the 3-bit add wraps naturally.
  always_comb begin
    w_rot = '0;
    for (int i = 0; i < N_CLIENTS; i++) begin
      w_rot[i] = req[ptr + IDX_W'(i)];
    end
  end

  // Fixed-priority encode of the rotated vector, lowest bit wins.
  always_comb begin
    w_off = '0;
    for (int i = N_CLIENTS - 1; i >= 0; i--) begin
      if (w_rot[i]) w_off = IDX_W'(i);
    end
  end

  assign any    = |req;
  assign winner = ptr + w_off;

endmodule

// File: rtl/rr_arbiter8.sv
// Eight-client round-robin arbiter with owner release and optional hold-time limit.
// gnt_idx/gnt_valid feed a 3-to-8 decoder (A/E); all outputs are registered.
module rr_arbiter8
  import rr_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_CLIENTS-1:0] req,
  input  logic                 done,
  output logic [IDX_W-1:0]     gnt_idx,
  output logic                 gnt_valid,
  output logic                 timeout
);

  localparam bit               HoldEn   = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  arb_state_e        r_state, w_state_next;
  logic [IDX_W-1:0]  r_ptr, w_ptr_next;
  logic [HOLD_W-1:0] r_hold_cnt, w_hold_next;
  logic [IDX_W-1:0]  r_gnt_idx, w_gnt_idx_next;
  logic              r_gnt_valid, w_gnt_valid_next;
  logic              r_timeout, w_timeout_next;

  logic              w_any;
  logic [IDX_W-1:0]  w_winner;
  logic              w_rel_norm;
  logic              w_rel_limit;

  rr_pick8 u_pick (
    .req    (req),
    .ptr    (r_ptr),
    .any    (w_any),
    .winner (w_winner)
  );

  // Owner release takes precedence over the hold limit, so a coincident done never times out.
  assign w_rel_norm  = done | ~req[r_gnt_idx];
  assign w_rel_limit = HoldEn && (r_hold_cnt == HoldLast);

  // State and output registers; reset drops the grant immediately with no bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_hold_cnt  <= '0;
      r_gnt_idx   <= '0;
      r_gnt_valid <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_ptr       <= w_ptr_next;
      r_hold_cnt  <= w_hold_next;
      r_gnt_idx   <= w_gnt_idx_next;
      r_gnt_valid <= w_gnt_valid_next;
      r_timeout   <= w_timeout_next;
    end
  end

  // Next-state: grant on any request, return to IDLE on any release.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_IDLE:  if (w_any) w_state_next = ST_GRANT;
      ST_GRANT: if (w_rel_norm || w_rel_limit) w_state_next = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs, pointer and hold counter.
  always_comb begin
    w_ptr_next       = r_ptr;
    w_hold_next      = r_hold_cnt;
    w_gnt_idx_next   = r_gnt_idx;
    w_gnt_valid_next = r_gnt_valid;
    w_timeout_next   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_gnt_idx_next   = w_winner;
          w_gnt_valid_next = 1'b1;
          w_hold_next      = '0;
        end
      end
      ST_GRANT: begin
        if (w_rel_norm) begin
          w_gnt_valid_next = 1'b0;
          w_ptr_next       = r_gnt_idx + IDX_W'(1);
        end else if (w_rel_limit) begin
          w_gnt_valid_next = 1'b0;
          w_timeout_next   = 1'b1;
          w_ptr_next       = r_gnt_idx + IDX_W'(1);
        end else if (r_hold_cnt != '1) begin
          // Saturates only when the limit is disabled.
          w_hold_next = r_hold_cnt + HOLD_W'(1);
        end
      end
    endcase
  end

  assign gnt_idx   = r_gnt_idx;
  assign gnt_valid = r_gnt_valid;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_rr_arbiter8.sv
// Scoreboard bench for rr_arbiter8: a per-cycle reference model queues expected outputs,
// a negedge monitor pops and compares them; directed spot checks follow the test plan.
module tb_rr_arbiter8;

  localparam int unsigned MH = 4;

  typedef struct packed {
    logic       v;
    logic [2:0] idx;
    logic       t;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int   n_cmp = 0;
  int   n_bad = 0;
  bit   mon_en = 1'b0;
  exp_t sb_q[$];

  rr_arbiter8 #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  // Reference model: owner (or none), rotating start point, count of valid cycles so far.
  int m_ptr = 0, m_idx = 0, m_age = 0;
  bit m_busy = 0, m_tmo = 0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_ptr = 0; m_idx = 0; m_age = 0; m_busy = 0; m_tmo = 0;
        sb_q.delete();
      end else begin
        m_tmo = 0;
        if (!m_busy) begin
          for (int k = 0; k < 8; k++) begin
            if (!m_busy && req[(m_ptr + k) % 8]) begin
              m_idx  = (m_ptr + k) % 8;
              m_busy = 1;
              m_age  = 1;
            end
          end
        end else if (done || !req[m_idx]) begin
          m_busy = 0;
          m_ptr  = (m_idx + 1) % 8;
        end else if (MH != 0 && m_age == int'(MH)) begin
          m_busy = 0;
          m_tmo  = 1;
          m_ptr  = (m_idx + 1) % 8;
        end else begin
          m_age++;
        end
      end
      sb_q.push_back('{v: m_busy, idx: 3'(m_idx), t: m_tmo});
    end
  end

  // Monitor: one expected entry per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (mon_en) begin
      exp_t e;
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_bad++;
        $display("FAIL sb_empty t=%0t no expected entry queued", $time);
      end else begin
        e = sb_q.pop_front();
        if (gnt_valid !== e.v || gnt_idx !== e.idx || timeout !== e.t) begin
          n_bad++;
          $display("FAIL out_cycle t=%0t actual v=%0b idx=%0d to=%0b required v=%0b idx=%0d to=%0b",
                   $time, gnt_valid, gnt_idx, timeout, e.v, e.idx, e.t);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
    end
  endtask

  initial begin
    tick(); tick();
    mon_en = 1'b1;
    tick();
    chk("rst_valid", int'(gnt_valid), 0);
    chk("rst_idx", int'(gnt_idx), 0);
    chk("rst_timeout", int'(timeout), 0);
    rst = 1'b0;
    tick();

    // Full load with done one cycle after each grant: 0..7 then wrap to 0.
    req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      tick();
      chk("rr_valid", int'(gnt_valid), 1);
      chk("rr_idx", int'(gnt_idx), g % 8);
      done = 1'b1;
      tick();
      done = 1'b0;
      chk("rr_gap", int'(gnt_valid), 0);
    end
    req = 8'h00;
    tick();

    // Single requester 2 (pointer now 1).
    req = 8'b0000_0100;
    tick();
    chk("single_idx", int'(gnt_idx), 2);
    chk("single_valid", int'(gnt_valid), 1);
    req = 8'h00;
    tick();
    chk("drop_release", int'(gnt_valid), 0);

    // Pointer 3, requests 0 and 2: search wraps to 0.
    req = 8'b0000_0101;
    tick();
    chk("wrap_idx", int'(gnt_idx), 0);
    req = 8'h00;
    tick(); tick();

    // Hold limit: client 1 valid for exactly MH cycles, then timeout, then client 7.
    req = 8'b1000_0010;
    for (int c = 0; c < int'(MH); c++) begin
      tick();
      chk("hold_valid", int'(gnt_valid), 1);
      chk("hold_idx", int'(gnt_idx), 1);
    end
    tick();
    chk("limit_valid", int'(gnt_valid), 0);
    chk("limit_timeout", int'(timeout), 1);
    tick();
    chk("after_limit_idx", int'(gnt_idx), 7);
    chk("after_limit_to", int'(timeout), 0);
    req = 8'h00;
    tick(); tick();

    // done coincides with the last allowed cycle: normal release, no timeout.
    req = 8'h01;
    tick();
    tick(); tick(); tick();
    done = 1'b1;
    req  = 8'h00;
    tick();
    chk("coinc_valid", int'(gnt_valid), 0);
    chk("coinc_timeout", int'(timeout), 0);
    tick();
    req = 8'h02;
    tick();
    chk("idle_done_idx", int'(gnt_idx), 1);
    done = 1'b0;
    tick();
    chk("idle_done_hold", int'(gnt_valid), 1);
    req = 8'h00;
    tick(); tick();

    // Asynchronous reset between edges mid-grant.
    req = 8'hFF;
    tick();
    #1 rst = 1'b1;
    #1 chk("async_rst_valid", int'(gnt_valid), 0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idx", int'(gnt_idx), 0);
    chk("post_rst_valid", int'(gnt_valid), 1);

    // Randomized traffic; requests change occasionally so hold limits get exercised.
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        logic [31:0] r;
        r   = $urandom;
        req = ($urandom_range(0, 4) == 0) ? 8'h00 : (r[7:0] | r[15:8]);
      end
      done = ($urandom_range(0, 5) == 0);
      tick();
    end
    req  = 8'h00;
    done = 1'b0;
    tick(); tick();
    mon_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
